spike_rate_monitor: RTL and testbench



---
 rtl/spike_rate_monitor.sv | 150 +++++++++++++++
 tb/tb_spike_rate_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_monitor.sv
// Spike train metrics: per-window spike count (firing rate) and the
// inter-spike interval, both reported on registered buses with one-cycle
// valid strobes.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   en          - count enable; all counters freeze while low
//   spike       - neuron spike output (level)
//   rate_out    - spike count of the last completed window (saturating)
//   rate_valid  - one-cycle strobe, rate_out/rate_ovf updated
//   rate_ovf    - last completed window saturated its count
//   isi_out     - enabled cycles between the two most recent spike edges
//   isi_valid   - one-cycle strobe, isi_out updated
module spike_rate_monitor #(
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ISI_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_ovf,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid
);

    localparam int unsigned WIN_W = $clog2(WIN_LEN);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    typedef enum logic {
        NO_SPIKE = 1'b0,
        TRACK    = 1'b1
    } isi_state_e;

    isi_state_e       state_q, state_d;
    logic             spike_dly_q;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [CNT_W-1:0] rate_out_q, rate_out_d;
    logic             rate_valid_q, rate_valid_d;
    logic             rate_ovf_q, rate_ovf_d;
    logic [ISI_W-1:0] isi_out_q, isi_out_d;
    logic             isi_valid_q, isi_valid_d;

    logic             spike_edge_c;
    logic [SUM_W-1:0] acc_sum_c;
    logic [CNT_W-1:0] acc_sat_c;
    logic [ISI_W-1:0] isi_inc_c;

    // Rising edge of spike, qualified by enable; a held spike counts once.
    assign spike_edge_c = spike & ~spike_dly_q & en;

    // Accumulator arithmetic with carry kept to detect saturation.
    assign acc_sum_c = {1'b0, acc_q} + SUM_W'(spike_edge_c);
    assign acc_sat_c = acc_sum_c[CNT_W] ? CNT_MAX : acc_sum_c[CNT_W-1:0];
    assign isi_inc_c = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);

    // Next-state: window accounting and ISI tracking.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        win_cnt_d    = win_cnt_q;
        isi_cnt_d    = isi_cnt_q;
        rate_out_d   = rate_out_q;
        rate_ovf_d   = rate_ovf_q;
        rate_valid_d = 1'b0;
        isi_out_d    = isi_out_q;
        isi_valid_d  = 1'b0;

        if (en) begin
            // An edge on the closing cycle still belongs to the closing window.
            if (win_cnt_q == WIN_LAST) begin
                rate_out_d   = acc_sat_c;
                rate_ovf_d   = ovf_q | acc_sum_c[CNT_W];
                rate_valid_d = 1'b1;
                acc_d        = '0;
                ovf_d        = 1'b0;
                win_cnt_d    = '0;
            end else begin
                acc_d     = acc_sat_c;
                ovf_d     = ovf_q | acc_sum_c[CNT_W];
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
        end

        case (state_q)
            NO_SPIKE: begin
                if (spike_edge_c) begin
                    state_d   = TRACK;
                    isi_cnt_d = ISI_W'(1);
                end
            end
            TRACK: begin
                if (spike_edge_c) begin
                    isi_out_d   = isi_cnt_q;
                    isi_valid_d = 1'b1;
                    isi_cnt_d   = ISI_W'(1);
                end else if (en) begin
                    isi_cnt_d = isi_inc_c;
                end
            end
            default: state_d = NO_SPIKE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NO_SPIKE;
            spike_dly_q  <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            win_cnt_q    <= '0;
            isi_cnt_q    <= '0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            rate_ovf_q   <= 1'b0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_dly_q  <= spike;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            win_cnt_q    <= win_cnt_d;
            isi_cnt_q    <= isi_cnt_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            rate_ovf_q   <= rate_ovf_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign rate_ovf   = rate_ovf_q;
    assign isi_out    = isi_out_q;
    assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench: two monitors share one stimulus stream. Instance a uses
// wide counters (16/8/8), instance b narrow ones (16/2/4) to exercise
// count and ISI saturation. Expected strobes are queued per phase; a
// negedge monitor pops and compares whenever a valid strobe appears.
module tb_spike_rate_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       spike = 1'b0;

    logic [7:0] rate_out_a;
    logic       rate_valid_a, rate_ovf_a;
    logic [7:0] isi_out_a;
    logic       isi_valid_a;
    logic [1:0] rate_out_b;
    logic       rate_valid_b, rate_ovf_b;
    logic [3:0] isi_out_b;
    logic       isi_valid_b;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    bit mon_on   = 1'b0;

    int q_rate_a[$];
    int q_rate_b[$];
    int q_isi_a[$];
    int q_isi_b[$];

    spike_rate_monitor #(.WIN_LEN(16), .CNT_W(8), .ISI_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .spike(spike),
        .rate_out(rate_out_a), .rate_valid(rate_valid_a), .rate_ovf(rate_ovf_a),
        .isi_out(isi_out_a), .isi_valid(isi_valid_a)
    );

    spike_rate_monitor #(.WIN_LEN(16), .CNT_W(2), .ISI_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .spike(spike),
        .rate_out(rate_out_b), .rate_valid(rate_valid_b), .rate_ovf(rate_ovf_b),
        .isi_out(isi_out_b), .isi_valid(isi_valid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: strobe with no expected entry (t=%0d)", name, t);
    endtask

    // One clock with the given inputs; t counts enabled, non-reset cycles.
    task automatic step(input logic sp, input logic e);
        spike = sp;
        en    = e;
        @(posedge clk);
        #1;
        if (!rst && e) t++;
    endtask

    task automatic go_to(input int target);
        while (t < target) step(1'b0, 1'b1);
    endtask

    task automatic pulse_at(input int target);
        go_to(target);
        step(1'b1, 1'b1);
    endtask

    // Rate entries are encoded as count*2 + ovf.
    task automatic push_rate(input int ra, input int oa, input int rb, input int ob);
        q_rate_a.push_back(ra * 2 + oa);
        q_rate_b.push_back(rb * 2 + ob);
    endtask

    task automatic push_isi(input int a, input int b);
        q_isi_a.push_back(a);
        q_isi_b.push_back(b);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rate_out_a"}, 32'(rate_out_a), 0);
        check({tag, " rate_valid_a"}, 32'(rate_valid_a), 0);
        check({tag, " rate_ovf_a"}, 32'(rate_ovf_a), 0);
        check({tag, " isi_out_a"}, 32'(isi_out_a), 0);
        check({tag, " isi_valid_a"}, 32'(isi_valid_a), 0);
        check({tag, " rate_out_b"}, 32'(rate_out_b), 0);
        check({tag, " rate_valid_b"}, 32'(rate_valid_b), 0);
        check({tag, " rate_ovf_b"}, 32'(rate_ovf_b), 0);
        check({tag, " isi_out_b"}, 32'(isi_out_b), 0);
        check({tag, " isi_valid_b"}, 32'(isi_valid_b), 0);
    endtask

    // Monitor: pop and compare on every strobe, away from the active edge.
    always @(negedge clk) begin : monitor
        int e;
        if (mon_on) begin
            if (rate_valid_a === 1'b1) begin
                if (q_rate_a.size() == 0) unexpected("rate_a");
                else begin
                    e = q_rate_a.pop_front();
                    check("rate_a count", 32'(rate_out_a), 32'(e / 2));
                    check("rate_a ovf", 32'(rate_ovf_a), 32'(e % 2));
                end
            end
            if (rate_valid_b === 1'b1) begin
                if (q_rate_b.size() == 0) unexpected("rate_b");
                else begin
                    e = q_rate_b.pop_front();
                    check("rate_b count", 32'(rate_out_b), 32'(e / 2));
                    check("rate_b ovf", 32'(rate_ovf_b), 32'(e % 2));
                end
            end
            if (isi_valid_a === 1'b1) begin
                if (q_isi_a.size() == 0) unexpected("isi_a");
                else begin
                    e = q_isi_a.pop_front();
                    check("isi_a", 32'(isi_out_a), 32'(e));
                end
            end
            if (isi_valid_b === 1'b1) begin
                if (q_isi_b.size() == 0) unexpected("isi_b");
                else begin
                    e = q_isi_b.pop_front();
                    check("isi_b", 32'(isi_out_b), 32'(e));
                end
            end
        end
    end

    initial begin
        // Phase 1: reset then idle; empty windows, no ISI strobes.
        rst = 1'b1;
        step(1'b0, 1'b1);
        mon_on = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_zero("reset");
        rst = 1'b0;
        t   = 0;
        push_rate(0, 0, 0, 0);
        push_rate(0, 0, 0, 0);
        go_to(32);

        // Phase 2: 1-cycle spike every 4 cycles; first edge starts ISI tracking.
        push_rate(4, 0, 3, 1);
        push_rate(4, 0, 3, 1);
        for (int k = 0; k < 7; k++) push_isi(4, 4);
        for (int k = 0; k < 8; k++) pulse_at(32 + 4 * k);
        go_to(64);

        // Phase 3: 5-cycle held spike counts once; spike on the closing cycle.
        push_rate(1, 0, 1, 0);
        push_rate(1, 0, 1, 0);
        push_rate(0, 0, 0, 0);
        push_isi(6, 6);
        push_isi(29, 15);
        go_to(66);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        pulse_at(95);
        go_to(112);

        // Phase 4: alternating spikes, 8 edges in one window, then a quiet window.
        push_rate(8, 0, 3, 1);
        push_rate(0, 0, 0, 0);
        push_isi(17, 15);
        for (int k = 0; k < 7; k++) push_isi(2, 2);
        for (int k = 0; k < 8; k++) pulse_at(112 + 2 * k);
        go_to(144);

        // Phase 5: long gaps saturate narrow ISI; en=0 gap freezes counters
        // and drops the spike issued inside it.
        push_rate(1, 0, 1, 0);
        push_rate(0, 0, 0, 0);
        push_rate(2, 0, 2, 0);
        push_isi(18, 15);
        push_isi(40, 15);
        push_isi(6, 6);
        pulse_at(144);
        pulse_at(184);
        go_to(188);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        pulse_at(190);
        go_to(192);

        // Phase 6: reset with win_cnt=9 and acc=3 discards the partial window.
        push_isi(3, 3);
        push_isi(2, 2);
        push_isi(2, 2);
        pulse_at(193);
        pulse_at(195);
        pulse_at(197);
        go_to(201);
        rst = 1'b1;
        step(1'b0, 1'b1);
        check_zero("mid reset");
        step(1'b0, 1'b1);
        rst = 1'b0;
        t   = 0;
        push_rate(2, 0, 2, 0);
        push_isi(5, 5);
        pulse_at(3);
        pulse_at(8);
        go_to(16);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);

        check("rate_a missing strobes", 32'(q_rate_a.size()), 0);
        check("rate_b missing strobes", 32'(q_rate_b.size()), 0);
        check("isi_a missing strobes", 32'(q_isi_a.size()), 0);
        check("isi_b missing strobes", 32'(q_isi_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
